// File: rtl/swim_pkg.sv
// Shared SWIM definitions: status/command codes, default timing, frame builder.
package swim_pkg;

    typedef enum logic [1:0] {
        SWIM_ACK     = 2'b00,
        SWIM_NACK    = 2'b01,
        SWIM_TIMEOUT = 2'b10
    } swim_status_e;

    localparam logic [2:0] SWIM_SRST = 3'b000;
    localparam logic [2:0] SWIM_ROTF = 3'b001;
    localparam logic [2:0] SWIM_WOTF = 3'b010;

    localparam int unsigned SWIM_T_SHORT     = 12;
    localparam int unsigned SWIM_T_LONG      = 120;
    localparam int unsigned SWIM_ACK_TIMEOUT = 4096;
    localparam int unsigned SWIM_FRAME_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_ACK_WAIT,
        ST_ACK_LOW,
        ST_REPORT
    } swim_tx_state_e;

    // Left-aligned frame: header 0, payload MSB first, payload parity.
    function automatic logic [SWIM_FRAME_W-1:0] swim_build_frame(input logic is_cmd,
                                                                 input logic [7:0] data);
        if (is_cmd) begin
            swim_build_frame = {1'b0, data[2:0], ^data[2:0], 5'b00000};
        end else begin
            swim_build_frame = {1'b0, data, ^data};
        end
    endfunction

endpackage

// File: rtl/swim_in_sync.sv
// Two-flop synchronizer for the SWIM pad with registered edge pulses.
module swim_in_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic fall,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronize the idle-high pad and flag edges one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
            fall   <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            fall   <= sync_d & ~sync;
            rise   <= ~sync_d & sync;
        end
    end

endmodule

// File: rtl/swim_frame_tx.sv
// SWIM low-speed frame transmitter with target acknowledge decode.
module swim_frame_tx
    import swim_pkg::*;
#(
    parameter int unsigned T_SHORT     = SWIM_T_SHORT,
    parameter int unsigned T_LONG      = SWIM_T_LONG,
    parameter int unsigned ACK_TIMEOUT = SWIM_ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_is_cmd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       swim_oe,
    input  logic       swim_in,
    output logic [1:0] status,
    output logic       status_valid,
    output logic       busy
);

    localparam int unsigned PHASE_W    = 8;
    localparam int unsigned BIT_W      = 4;
    localparam int unsigned TMO_W      = 16;
    localparam int unsigned LOW_W      = 8;
    localparam int unsigned T_BIT      = T_SHORT + T_LONG;
    localparam int unsigned ACK_THRESH = T_BIT / 2;

    swim_tx_state_e            state, state_d;
    logic [PHASE_W-1:0]        phase_cnt, phase_d;
    logic [BIT_W-1:0]          bit_idx, bit_d;
    logic [TMO_W-1:0]          tmo_cnt, tmo_d;
    logic [LOW_W-1:0]          low_cnt, low_d;
    logic [SWIM_FRAME_W-1:0]   frame, frame_d;
    logic [BIT_W-1:0]          frame_len, len_d;
    logic [1:0]                status_d;
    logic                      cur_bit;
    logic                      oe_d;
    logic                      line_fall;
    logic                      line_rise;

    swim_in_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (swim_in),
        .fall    (line_fall),
        .rise    (line_rise)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            bit_idx      <= '0;
            tmo_cnt      <= '0;
            low_cnt      <= '0;
            frame        <= '0;
            frame_len    <= '0;
            swim_oe      <= 1'b0;
            in_ready     <= 1'b0;
            status       <= SWIM_ACK;
            status_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            phase_cnt    <= phase_d;
            bit_idx      <= bit_d;
            tmo_cnt      <= tmo_d;
            low_cnt      <= low_d;
            frame        <= frame_d;
            frame_len    <= len_d;
            swim_oe      <= oe_d;
            in_ready     <= (state_d == ST_IDLE);
            status       <= status_d;
            status_valid <= (state_d == ST_REPORT);
            busy         <= (state_d != ST_IDLE);
        end
    end

    // Next state, counter updates and next line drive level.
    always_comb begin
        state_d  = state;
        phase_d  = phase_cnt;
        bit_d    = bit_idx;
        tmo_d    = tmo_cnt;
        low_d    = low_cnt;
        frame_d  = frame;
        len_d    = frame_len;
        status_d = status;
        cur_bit  = 1'b0;
        oe_d     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ST_SEND;
                    frame_d = swim_build_frame(in_is_cmd, in_data);
                    len_d   = in_is_cmd ? BIT_W'(5) : BIT_W'(10);
                end
            end
            ST_SEND: begin
                if (phase_cnt == PHASE_W'(T_BIT - 1)) begin
                    phase_d = '0;
                    if (bit_idx == frame_len - BIT_W'(1)) begin
                        state_d = ST_ACK_WAIT;
                    end else begin
                        bit_d = bit_idx + BIT_W'(1);
                    end
                end else begin
                    phase_d = phase_cnt + PHASE_W'(1);
                end
            end
            ST_ACK_WAIT: begin
                if (line_fall) begin
                    state_d = ST_ACK_LOW;
                end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d  = ST_REPORT;
                    status_d = SWIM_TIMEOUT;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                end
            end
            ST_ACK_LOW: begin
                if (line_rise) begin
                    state_d  = ST_REPORT;
                    status_d = (low_cnt < LOW_W'(ACK_THRESH)) ? SWIM_ACK : SWIM_NACK;
                end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d  = ST_REPORT;
                    status_d = SWIM_TIMEOUT;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                    if (low_cnt != '1) begin
                        low_d = low_cnt + LOW_W'(1);
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry starts its counters from zero.
        if (state_d != state) begin
            phase_d = '0;
            bit_d   = '0;
            tmo_d   = '0;
            low_d   = '0;
        end

        cur_bit = frame_d[BIT_W'(SWIM_FRAME_W - 1) - bit_d];
        if (state_d == ST_SEND) begin
            oe_d = cur_bit ? (phase_d < PHASE_W'(T_SHORT)) : (phase_d < PHASE_W'(T_LONG));
        end
    end

endmodule
